vrs_coarse_coalescer: RTL and testbench
=======================================

# vrs_coarse_coalescer

Downstream neighbour of the VRS tier-2 shading-decision stage. Consumes per-fragment shading decisions (rate, shade flag, coordinates, primitive ID) and coalesces fragments sharing one coarse pixel into a single shading request. Each request carries the coarse-pixel anchor, footprint size and a 4x4 coverage mask. Requests are sent through a FIFO to shader dispatch, which shades once and broadcasts the result to every covered pixel.

## Interface
- FIFO_DEPTH, 4, request FIFO entries (power of two, ≥2)
- TIMEOUT, 16, idle cycles before an open group is forced out (1..255)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- frag_valid  in  1  fragment offered
- frag_ready  out  1  fragment accepted when valid&ready
- frag_x, frag_y  in  16 each  pixel coordinates
- frag_prim_id  in  32  primitive ID
- frag_rate  in  3  rate code 0..4
- frag_shade  in  1  upstream marked this pixel as the shaded anchor
- flush  in  1  one-cycle pulse, end of draw
- flush_done  out  1  one-cycle pulse, flush complete
- req_valid, req_ready  out/in  1  request handshake
- req_x, req_y  out  16 each  anchor coordinates
- req_size  out  3  footprint N (1..4)
- req_prim_id  out  32
- req_mask  out  16  bit (dy*4+dx) set = pixel (anchor+dx, anchor+dy) covered
- req_anchor_shaded  out  1  OR of frag_shade over the group
- perf_frags_in, perf_reqs  out  32 each  accepted fragments / completed request handshakes; wrap modulo 2^32

## Operation
- Footprint N by rate: 0→1, 1→2, 2→2, 3→3, 4→4. Codes 5..7 are treated as 0.
- Anchor: ax = x − (x mod N), ay = y − (y mod N). Bit index = (y−ay)*4 + (x−ax).
- Full mask for N: bits r*4+c set for r,c < N. Values: 1→0x0001, 2→0x0033, 3→0x0777, 4→0xFFFF.
- One open-group register holds key {ax, ay, N, prim_id}, mask, anchor_shaded, idle counter.
- On an accepted fragment, it merges (OR bit, OR shade, idle←0) only if all hold:
  - the group is open
  - the key matches
  - the registered mask is not full
  - idle ≠ TIMEOUT
- Otherwise the open group (if any) is enqueued, and a new group opens with this fragment (idle←0).
- With no fragment accepted, the open group is enqueued at the edge where any of these holds, provided the FIFO is not full; otherwise it stays open until the FIFO has space:
  - registered mask is full
  - idle == TIMEOUT
  - flush pending
- At most one enqueue per cycle. Idle counter increments each cycle the group stays open without a merge and saturates at TIMEOUT.
- frag_ready = !fifo_full && !flush_pending, from registered state only. A mismatch enqueue therefore always has room.
- Duplicate pixel (bit already set) with matching key: bit stays set, no error.
- Flush:
  - A flush pulse sets flush_pending.
  - flush_pending clears when no group is open and the FIFO is empty.
  - flush_done pulses in the cycle flush_pending clears.
  - A flush with nothing pending produces flush_done on the next cycle.
- Reset mid-operation:
  - the open group is discarded and the FIFO emptied
  - all outputs and counters return to 0

## Timing
- Reset values: frag_ready 0 during reset, 1 on the first cycle after; every other output 0.
- Fragment accepted at edge E0 → group registered. A full group is enqueued at E1; req_valid is high after E1. Minimum latency is 2 cycles with the FIFO empty (1x1 rate).
- FIFO output is registered and independent of frag_* signals (no combinational path from frag to req).
- req_* are held stable while req_valid && !req_ready.
- Enqueue and dequeue may occur in the same cycle. frag_ready does not reflect a same-cycle dequeue.

## Structure
- vrs_pkg holds:
  - rate code localparams
  - footprint_size(rate) and full_mask(N) functions
  - vrs_req_t packed struct {x, y, size, prim_id, mask, anchor_shaded}
- Sub-module vrs_req_fifo: synchronous FIFO of vrs_req_t, parameter DEPTH, full/empty flags, registered output.

## Test plan
- Rate 2, prim 7, fragments (8,4),(9,4),(8,5),(9,5) back-to-back with frag_shade on (8,4) → one request: x=8, y=4, size 2, mask 0x0033, anchor_shaded 1.
- Rate 0, fragment (5,5) at cycle 0 → req_valid at cycle 2: mask 0x0001, size 1.
- Rate 4, prim 7: (0,0),(1,0), then (2,0) with prim 8 → first request mask 0x0003, prim 7. Second request, after TIMEOUT idle cycles: mask 0x0004, prim 8, anchor_shaded 0.
- Rate 3, fragment (7,4) → after 16 idle cycles, request x=6, y=3, size 3, mask 0x0020.
- req_ready held 0, six rate-0 fragments → frag_ready drops once 4 entries are queued. Release req_ready → six requests in input order; perf_reqs=6, perf_frags_in=6.
- Flush with open group (rate 2, one fragment) → frag_ready 0, request emitted, flush_done pulses once after the FIFO drains. Assert rst with an open group → req_valid stays 0 and nothing is emitted.

Source files
------------

// File: rtl/vrs_pkg.sv
// Shared types and helpers for the VRS coarse-pixel coalescer: rate codes,
// footprint/mask helpers and the request record sent to shader dispatch.
package vrs_pkg;

  localparam logic [2:0] RATE_1X1    = 3'd0;
  localparam logic [2:0] RATE_2X2_LO = 3'd1;
  localparam logic [2:0] RATE_2X2_HI = 3'd2;
  localparam logic [2:0] RATE_3X3    = 3'd3;
  localparam logic [2:0] RATE_4X4    = 3'd4;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [2:0]  size;
    logic [31:0] prim_id;
    logic [15:0] mask;
    logic        anchor_shaded;
  } vrs_req_t;

  // Unknown rate codes fall back to per-pixel shading.
  function automatic logic [2:0] footprint_size(input logic [2:0] rate);
    case (rate)
      RATE_1X1:                 footprint_size = 3'd1;
      RATE_2X2_LO, RATE_2X2_HI: footprint_size = 3'd2;
      RATE_3X3:                 footprint_size = 3'd3;
      RATE_4X4:                 footprint_size = 3'd4;
      default:                  footprint_size = 3'd1;
    endcase
  endfunction

  function automatic logic [15:0] full_mask(input logic [2:0] n);
    case (n)
      3'd2:    full_mask = 16'h0033;
      3'd3:    full_mask = 16'h0777;
      3'd4:    full_mask = 16'hFFFF;
      default: full_mask = 16'h0001;
    endcase
  endfunction

  function automatic logic [15:0] anchor_coord(input logic [15:0] c, input logic [2:0] n);
    case (n)
      3'd2:    anchor_coord = {c[15:1], 1'b0};
      3'd3:    anchor_coord = c - (c % 16'd3);
      3'd4:    anchor_coord = {c[15:2], 2'b00};
      default: anchor_coord = c;
    endcase
  endfunction

endpackage

// File: rtl/vrs_req_fifo.sv
// Synchronous request FIFO; output is driven purely from stored state and
// reads as zero while empty.
module vrs_req_fifo
  import vrs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en_i,
  input  vrs_req_t wr_data_i,
  input  logic     rd_en_i,
  output vrs_req_t rd_data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  vrs_req_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_wr, do_rd;

  assign full_o    = (count_q == DEPTH_C);
  assign empty_o   = (count_q == '0);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vrs_coarse_coalescer.sv
// Coalesces per-fragment VRS shading decisions that share a coarse pixel into
// one shading request (anchor, footprint, 4x4 coverage) queued for dispatch.
module vrs_coarse_coalescer
  import vrs_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frag_valid,
  output logic        frag_ready,
  input  logic [15:0] frag_x,
  input  logic [15:0] frag_y,
  input  logic [31:0] frag_prim_id,
  input  logic [2:0]  frag_rate,
  input  logic        frag_shade,
  input  logic        flush,
  output logic        flush_done,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [15:0] req_x,
  output logic [15:0] req_y,
  output logic [2:0]  req_size,
  output logic [31:0] req_prim_id,
  output logic [15:0] req_mask,
  output logic        req_anchor_shaded,
  output logic [31:0] perf_frags_in,
  output logic [31:0] perf_reqs
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  // Handshakes: a fragment transfers on an edge where frag_valid && frag_ready;
  // a request transfers on an edge where req_valid && req_ready, and req_*
  // hold steady while req_valid is high and req_ready is low.

  vrs_req_t    grp_q, grp_d;
  logic        open_q, open_d;
  logic [7:0]  idle_q, idle_d;
  logic        flush_pending_q, flush_pending_d;
  logic        ready_en_q;
  logic [31:0] frags_in_q, reqs_q;

  logic [2:0]  frag_n;
  logic [15:0] frag_ax, frag_ay;
  logic [1:0]  frag_dx, frag_dy;
  logic [15:0] frag_bit;
  logic        accept, key_match, mask_full, timed_out, merge, enq;
  logic        fifo_full, fifo_empty, flush_clear;
  vrs_req_t    fifo_out;

  assign frag_n   = footprint_size(frag_rate);
  assign frag_ax  = anchor_coord(frag_x, frag_n);
  assign frag_ay  = anchor_coord(frag_y, frag_n);
  assign frag_dx  = frag_x[1:0] - frag_ax[1:0];
  assign frag_dy  = frag_y[1:0] - frag_ay[1:0];
  assign frag_bit = 16'd1 << {frag_dy, frag_dx};

  // Ready depends only on registered state, so a mismatch enqueue always fits.
  assign frag_ready = ready_en_q && !fifo_full && !flush_pending_q;
  assign accept     = frag_valid && frag_ready;

  assign key_match = (grp_q.x == frag_ax) && (grp_q.y == frag_ay) &&
                     (grp_q.size == frag_n) && (grp_q.prim_id == frag_prim_id);
  assign mask_full = (grp_q.mask == full_mask(grp_q.size));
  assign timed_out = (idle_q == TIMEOUT_C);
  assign merge     = accept && open_q && key_match && !mask_full && !timed_out;

  always_comb begin
    grp_d  = grp_q;
    open_d = open_q;
    idle_d = idle_q;
    enq    = 1'b0;
    if (merge) begin
      grp_d.mask          = grp_q.mask | frag_bit;
      grp_d.anchor_shaded = grp_q.anchor_shaded | frag_shade;
      idle_d              = '0;
    end else if (accept) begin
      enq                 = open_q;
      grp_d.x             = frag_ax;
      grp_d.y             = frag_ay;
      grp_d.size          = frag_n;
      grp_d.prim_id       = frag_prim_id;
      grp_d.mask          = frag_bit;
      grp_d.anchor_shaded = frag_shade;
      open_d              = 1'b1;
      idle_d              = '0;
    end else if (open_q) begin
      if ((mask_full || timed_out || flush_pending_q) && !fifo_full) begin
        enq    = 1'b1;
        open_d = 1'b0;
        idle_d = '0;
      end else if (!timed_out) begin
        idle_d = idle_q + 8'd1;
      end
    end
  end

  assign flush_clear     = flush_pending_q && !open_q && fifo_empty;
  assign flush_pending_d = (flush_pending_q && !flush_clear) || flush;
  assign flush_done      = flush_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_q           <= '0;
      open_q          <= 1'b0;
      idle_q          <= '0;
      flush_pending_q <= 1'b0;
      ready_en_q      <= 1'b0;
      frags_in_q      <= '0;
      reqs_q          <= '0;
    end else begin
      grp_q           <= grp_d;
      open_q          <= open_d;
      idle_q          <= idle_d;
      flush_pending_q <= flush_pending_d;
      ready_en_q      <= 1'b1;
      if (accept) frags_in_q <= frags_in_q + 32'd1;
      if (req_valid && req_ready) reqs_q <= reqs_q + 32'd1;
    end
  end

  vrs_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (enq),
    .wr_data_i (grp_q),
    .rd_en_i   (req_ready),
    .rd_data_o (fifo_out),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign req_valid         = !fifo_empty;
  assign req_x             = fifo_out.x;
  assign req_y             = fifo_out.y;
  assign req_size          = fifo_out.size;
  assign req_prim_id       = fifo_out.prim_id;
  assign req_mask          = fifo_out.mask;
  assign req_anchor_shaded = fifo_out.anchor_shaded;
  assign perf_frags_in     = frags_in_q;
  assign perf_reqs         = reqs_q;

endmodule

// File: tb/tb_vrs_coarse_coalescer.sv
// Bench for vrs_coarse_coalescer: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a group-level reference model.
`timescale 1ns/1ps
module tb_vrs_coarse_coalescer;
  import vrs_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 16;
  localparam int W          = $bits(vrs_req_t);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frag_valid = 1'b0;
  logic        frag_ready;
  logic [15:0] frag_x = '0, frag_y = '0;
  logic [31:0] frag_prim_id = '0;
  logic [2:0]  frag_rate = '0;
  logic        frag_shade = 1'b0;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic [15:0] req_x, req_y;
  logic [2:0]  req_size;
  logic [31:0] req_prim_id;
  logic [15:0] req_mask;
  logic        req_anchor_shaded;
  logic [31:0] perf_frags_in, perf_reqs;

  always #5 clk = ~clk;

  vrs_coarse_coalescer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .frag_valid       (frag_valid),
    .frag_ready       (frag_ready),
    .frag_x           (frag_x),
    .frag_y           (frag_y),
    .frag_prim_id     (frag_prim_id),
    .frag_rate        (frag_rate),
    .frag_shade       (frag_shade),
    .flush            (flush),
    .flush_done       (flush_done),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_x            (req_x),
    .req_y            (req_y),
    .req_size         (req_size),
    .req_prim_id      (req_prim_id),
    .req_mask         (req_mask),
    .req_anchor_shaded(req_anchor_shaded),
    .perf_frags_in    (perf_frags_in),
    .perf_reqs        (perf_reqs)
  );

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  int rr_mode = 1;
  int edge_n = 0;
  bit last_acc;

  // Reference model: one open coarse group described at the request level.
  bit          m_open = 0;
  int          m_last, m_n;
  int          m_x, m_y;
  logic [31:0] m_prim;
  logic [15:0] m_mask;
  bit          m_shade;
  int          m_pushes = 0;
  int          m_accepts = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int ref_size(input int rate);
    if (rate == 1 || rate == 2) return 2;
    if (rate == 3) return 3;
    if (rate == 4) return 4;
    return 1;
  endfunction

  function automatic logic [15:0] ref_full(input int n);
    logic [15:0] m = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) m[r*4+c] = 1'b1;
    return m;
  endfunction

  task automatic model_close();
    if (m_open) begin
      exp_q.push_back({16'(m_x), 16'(m_y), 3'(m_n), m_prim, m_mask, m_shade});
      m_pushes++;
      m_open = 0;
    end
  endtask

  task automatic model_reset();
    m_open = 0;
    exp_q.delete();
    m_pushes = 0;
    m_accepts = 0;
  endtask

  task automatic model_edge(input bit acc, input int x, input int y, input logic [31:0] prim,
                            input int rate, input bit shade, input bit fl);
    int n, ax, ay, b;
    if (m_open && (edge_n - m_last) > TIMEOUT) model_close();
    if (acc) begin
      m_accepts++;
      n  = ref_size(rate);
      ax = x - (x % n);
      ay = y - (y % n);
      b  = (y - ay) * 4 + (x - ax);
      if (m_open && ax == m_x && ay == m_y && n == m_n && prim == m_prim &&
          m_mask != ref_full(n)) begin
        m_mask[b] = 1'b1;
        m_shade   = m_shade | shade;
      end else begin
        model_close();
        m_open  = 1;
        m_x     = ax;
        m_y     = ay;
        m_n     = n;
        m_prim  = prim;
        m_mask  = '0;
        m_mask[b] = 1'b1;
        m_shade = shade;
      end
      m_last = edge_n;
      if (m_mask == ref_full(m_n)) model_close();
    end
    if (fl) model_close();
  endtask

  // One clock: inputs change just after a rising edge and apply at the next.
  task automatic step(input bit v, input logic [15:0] x, input logic [15:0] y,
                      input logic [31:0] prim, input logic [2:0] rate,
                      input bit shade, input bit fl);
    @(posedge clk); #1;
    frag_valid   = v;
    frag_x       = x;
    frag_y       = y;
    frag_prim_id = prim;
    frag_rate    = rate;
    frag_shade   = shade;
    flush        = fl;
    case (rr_mode)
      0:       req_ready = 1'b0;
      1:       req_ready = 1'b1;
      default: req_ready = 1'($urandom_range(0, 1));
    endcase
    last_acc = v && frag_ready;
    edge_n++;
    model_edge(last_acc, int'(x), int'(y), prim, int'(rate), shade, fl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'd0, 16'd0, 32'd0, 3'd0, 0, 0);
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [31:0] prim,
                      input logic [2:0] rate, input bit shade);
    int budget = 0;
    do begin
      step(1, x, y, prim, rate, shade, 0);
      budget++;
    end while (!last_acc && budget < 200);
    if (!last_acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no accept for (%0d,%0d) expected accept", x, y);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    frag_valid = 1'b0;
    flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every completed request must match the oldest expectation.
  logic [W-1:0] mon_act, mon_exp;
  always @(negedge clk) begin
    if (!rst && req_valid && req_ready) begin
      mon_act = {req_x, req_y, req_size, req_prim_id, req_mask, req_anchor_shaded};
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL req_unexpected: got %0h expected none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("req", mon_act, mon_exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, done_cnt, vcnt, budget;
    bit seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_frag_ready", frag_ready, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_req_mask", req_mask, 0);
    check("rst_perf_frags", perf_frags_in, 0);
    check("rst_perf_reqs", perf_reqs, 0);
    rst = 1'b0;
    idle(1);
    check("post_rst_frag_ready", frag_ready, 1);

    // 2x2 quad with the anchor shaded
    rr_mode = 1;
    send(16'd8, 16'd4, 32'd7, 3'd2, 1);
    send(16'd9, 16'd4, 32'd7, 3'd2, 0);
    send(16'd8, 16'd5, 32'd7, 3'd2, 0);
    send(16'd9, 16'd5, 32'd7, 3'd2, 0);
    idle(4);
    check("quad_drained", exp_q.size(), 0);

    // 1x1 latency
    step(1, 16'd5, 16'd5, 32'd3, 3'd0, 0, 0);
    check("lat_accept", last_acc, 1);
    step(0, 16'd0, 16'd0, 32'd0, 3'd0, 0, 0);
    check("lat_valid_c1", req_valid, 0);
    step(0, 16'd0, 16'd0, 32'd0, 3'd0, 0, 0);
    check("lat_valid_c2", req_valid, 1);
    check("lat_size", req_size, 1);
    check("lat_mask", req_mask, 16'h0001);
    idle(3);

    // Primitive change splits a 4x4 group; the remainder leaves on timeout
    send(16'd0, 16'd0, 32'd7, 3'd4, 0);
    send(16'd1, 16'd0, 32'd7, 3'd4, 0);
    send(16'd2, 16'd0, 32'd8, 3'd4, 0);
    idle(TIMEOUT + 4);
    check("prim_split_drained", exp_q.size(), 0);

    // 3x3 anchor arithmetic
    send(16'd7, 16'd4, 32'd5, 3'd3, 0);
    idle(TIMEOUT + 4);
    check("rate3_drained", exp_q.size(), 0);

    // Backpressure
    do_reset();
    rr_mode = 0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      step(k < 6, 16'(20 + 2 * k), 16'd30, 32'd9, 3'd0, 0, 0);
      if (last_acc) k++;
    end
    check("bp_accepted", k, 5);
    check("bp_frag_ready", frag_ready, 0);
    check("bp_req_valid", req_valid, 1);
    check("bp_perf_frags", perf_frags_in, 5);
    rr_mode = 1;
    budget = 0;
    while (k < 6 && budget < 50) begin
      step(1, 16'(20 + 2 * k), 16'd30, 32'd9, 3'd0, 0, 0);
      if (last_acc) k++;
      budget++;
    end
    idle(10);
    check("bp_drained", exp_q.size(), 0);
    check("bp_perf_reqs", perf_reqs, 6);
    check("bp_perf_frags_all", perf_frags_in, 6);

    // Flush with an open group
    send(16'd40, 16'd40, 32'd11, 3'd2, 0);
    step(0, 16'd0, 16'd0, 32'd0, 3'd0, 0, 1);
    step(0, 16'd0, 16'd0, 32'd0, 3'd0, 0, 0);
    check("flush_blocks_ready", frag_ready, 0);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (flush_done) begin
        done_cnt++;
        check("flush_done_drained", exp_q.size(), 0);
        check("flush_done_req_valid", req_valid, 0);
      end
      step(0, 16'd0, 16'd0, 32'd0, 3'd0, 0, 0);
    end
    check("flush_done_count", done_cnt, 1);
    check("flush_ready_back", frag_ready, 1);

    // Flush with nothing pending
    step(0, 16'd0, 16'd0, 32'd0, 3'd0, 0, 1);
    step(0, 16'd0, 16'd0, 32'd0, 3'd0, 0, 0);
    check("flush_empty_done", flush_done, 1);
    step(0, 16'd0, 16'd0, 32'd0, 3'd0, 0, 0);
    check("flush_empty_single", flush_done, 0);

    // Reset discards an open group
    send(16'd50, 16'd50, 32'd12, 3'd2, 0);
    do_reset();
    vcnt = 0;
    for (int c = 0; c < TIMEOUT + 6; c++) begin
      step(0, 16'd0, 16'd0, 32'd0, 3'd0, 0, 0);
      if (req_valid) vcnt++;
    end
    check("rst_mid_no_req", vcnt, 0);
    check("rst_mid_perf_reqs", perf_reqs, 0);
    check("rst_mid_perf_frags", perf_frags_in, 0);

    // Randomized traffic around a few coarse neighbourhoods
    rr_mode = 2;
    for (int c = 0; c < 600; c++) begin
      logic [15:0] bx, by;
      bx = ($urandom_range(0, 1) == 0) ? 16'd12 : 16'd65528;
      by = ($urandom_range(0, 1) == 0) ? 16'd24 : 16'd3;
      if ($urandom_range(0, 60) == 0) idle($urandom_range(TIMEOUT - 2, TIMEOUT + 3));
      step($urandom_range(0, 3) != 0,
           bx + 16'($urandom_range(0, 4)), by + 16'($urandom_range(0, 4)),
           32'(100 + $urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), $urandom_range(0, 80) == 0);
    end
    rr_mode = 1;
    step(0, 16'd0, 16'd0, 32'd0, 3'd0, 0, 1);
    seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      step(0, 16'd0, 16'd0, 32'd0, 3'd0, 0, 0);
      if (flush_done) seen = 1;
    end
    check("rand_flush_done", seen, 1);
    idle(3);
    check("rand_drained", exp_q.size(), 0);
    check("rand_perf_reqs", perf_reqs, 32'(m_pushes));
    check("rand_perf_frags", perf_frags_in, 32'(m_accepts));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
